// File: rtl/alu_op_sequencer.sv
// Four-state sequencer (IDLE/READ/EXEC/WRITE) driving one ALU op per instruction.
// Define ALU_SEQ_PERF_EN to add the OpCount completion counter.
module alu_op_sequencer #(
    parameter int         DATA_W    = 8,
    parameter int         ADDR_W    = 2,
    parameter logic [3:0] NOWB_MASK = 4'b0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              InsValid,
    output logic              InsReady,
    input  logic [1:0]        InsOp,
    input  logic [ADDR_W-1:0] InsDst,
    input  logic [ADDR_W-1:0] InsSrcA,
    input  logic [ADDR_W-1:0] InsSrcB,
    output logic [ADDR_W-1:0] RFrdAddrA,
    output logic [ADDR_W-1:0] RFrdAddrB,
    input  logic [DATA_W-1:0] RFrdDataA,
    input  logic [DATA_W-1:0] RFrdDataB,
    output logic              RFwrEn,
    output logic [ADDR_W-1:0] RFwrAddr,
    output logic [DATA_W-1:0] RFwrData,
    output logic [1:0]        InsSel,
    output logic [DATA_W-1:0] ALUinA,
    output logic [DATA_W-1:0] ALUinB,
    input  logic [DATA_W-1:0] ALUout,
    input  logic              CO,
    input  logic              Z,
    output logic              FlagC,
    output logic              FlagZ,
    output logic              Busy,
    output logic              Done
`ifdef ALU_SEQ_PERF_EN
    ,
    output logic [15:0]       OpCount
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t            state;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] srca_q;
    logic [ADDR_W-1:0] srcb_q;
    logic              co_q;
    logic              z_q;
    logic              wr_q;

    assign InsReady  = (state == IDLE);
    assign Busy      = ~InsReady;
    assign RFrdAddrA = srca_q;
    assign RFrdAddrB = srcb_q;
    // Reset landing in WRITE must suppress the write in that same cycle
    assign RFwrEn    = wr_q & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= '0;
            dst_q    <= '0;
            srca_q   <= '0;
            srcb_q   <= '0;
            co_q     <= 1'b0;
            z_q      <= 1'b0;
            wr_q     <= 1'b0;
            InsSel   <= '0;
            ALUinA   <= '0;
            ALUinB   <= '0;
            RFwrAddr <= '0;
            RFwrData <= '0;
            FlagC    <= 1'b0;
            FlagZ    <= 1'b0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            wr_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (InsValid) begin
                        op_q   <= InsOp;
                        dst_q  <= InsDst;
                        srca_q <= InsSrcA;
                        srcb_q <= InsSrcB;
                        state  <= READ;
                    end
                end
                READ: begin
                    ALUinA <= RFrdDataA;
                    ALUinB <= RFrdDataB;
                    InsSel <= op_q;
                    state  <= EXEC;
                end
                EXEC: begin
                    RFwrData <= ALUout;
                    RFwrAddr <= dst_q;
                    co_q     <= CO;
                    z_q      <= Z;
                    wr_q     <= ~NOWB_MASK[op_q];
                    Done     <= 1'b1;
                    state    <= WRITE;
                end
                WRITE: begin
                    FlagC <= co_q;
                    FlagZ <= z_q;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_PERF_EN
    logic [15:0] op_count;

    assign OpCount = op_count;

    always_ff @(posedge clk) begin
        if (rst)
            op_count <= '0;
        else if (Done)
            op_count <= op_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a 4x8 register file and ALU model.
// Instantiated with NOWB_MASK = 4'b0010 so SUB acts as compare-only.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       InsValid;
    logic       InsReady;
    logic [1:0] InsOp;
    logic [1:0] InsDst;
    logic [1:0] InsSrcA;
    logic [1:0] InsSrcB;
    logic [1:0] RFrdAddrA;
    logic [1:0] RFrdAddrB;
    logic [7:0] RFrdDataA;
    logic [7:0] RFrdDataB;
    logic       RFwrEn;
    logic [1:0] RFwrAddr;
    logic [7:0] RFwrData;
    logic [1:0] InsSel;
    logic [7:0] ALUinA;
    logic [7:0] ALUinB;
    logic [7:0] ALUout;
    logic       CO;
    logic       Z;
    logic       FlagC;
    logic       FlagZ;
    logic       Busy;
    logic       Done;
`ifdef ALU_SEQ_PERF_EN
    logic [15:0] OpCount;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] rf [4];
    logic       ld_en = 1'b0;
    logic [1:0] ld_addr = '0;
    logic [7:0] ld_data = '0;
    logic [8:0] alu_full;

    always #5 clk = ~clk;

    alu_op_sequencer #(
        .DATA_W(8),
        .ADDR_W(2),
        .NOWB_MASK(4'b0010)
    ) dut (
        .clk(clk),
        .rst(rst),
        .InsValid(InsValid),
        .InsReady(InsReady),
        .InsOp(InsOp),
        .InsDst(InsDst),
        .InsSrcA(InsSrcA),
        .InsSrcB(InsSrcB),
        .RFrdAddrA(RFrdAddrA),
        .RFrdAddrB(RFrdAddrB),
        .RFrdDataA(RFrdDataA),
        .RFrdDataB(RFrdDataB),
        .RFwrEn(RFwrEn),
        .RFwrAddr(RFwrAddr),
        .RFwrData(RFwrData),
        .InsSel(InsSel),
        .ALUinA(ALUinA),
        .ALUinB(ALUinB),
        .ALUout(ALUout),
        .CO(CO),
        .Z(Z),
        .FlagC(FlagC),
        .FlagZ(FlagZ),
        .Busy(Busy),
        .Done(Done)
`ifdef ALU_SEQ_PERF_EN
        ,
        .OpCount(OpCount)
`endif
    );

    // Register file: combinational read, clocked write or bench preload
    assign RFrdDataA = rf[RFrdAddrA];
    assign RFrdDataB = rf[RFrdAddrB];

    always @(posedge clk) begin
        if (ld_en)
            rf[ld_addr] <= ld_data;
        else if (RFwrEn)
            rf[RFwrAddr] <= RFwrData;
    end

    // ALU: 00 ADD, 01 SUB (CO = borrow), 10 AND, 11 OR
    always_comb begin
        alu_full = '0;
        case (InsSel)
            2'b00: alu_full = {1'b0, ALUinA} + {1'b0, ALUinB};
            2'b01: alu_full = {1'b0, ALUinA} - {1'b0, ALUinB};
            2'b10: alu_full = {1'b0, ALUinA & ALUinB};
            default: alu_full = {1'b0, ALUinA | ALUinB};
        endcase
    end
    assign ALUout = alu_full[7:0];
    assign CO     = alu_full[8];
    assign Z      = (alu_full[7:0] == 8'h00);

    task automatic set_reg(input logic [1:0] a, input logic [7:0] v);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = v;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    // Handshake in one cycle, then scramble fields to prove they are ignored
    task automatic issue(input logic [1:0] op, input logic [1:0] dst,
                         input logic [1:0] a, input logic [1:0] b);
        @(negedge clk);
        InsValid = 1'b1;
        InsOp    = op;
        InsDst   = dst;
        InsSrcA  = a;
        InsSrcB  = b;
        @(posedge clk);
        #1;
        InsValid = 1'b0;
        InsOp    = ~op;
        InsDst   = ~dst;
        InsSrcA  = ~a;
        InsSrcB  = ~b;
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        InsValid = 1'b0;
        InsOp    = '0;
        InsDst   = '0;
        InsSrcA  = '0;
        InsSrcB  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        vectors++; if (InsReady !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %b exp 1", InsReady); end
        vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b exp 0", Busy); end
        vectors++; if (Done !== 1'b0 || RFwrEn !== 1'b0) begin miscompares++; $display("FAIL rst_done_wr got %b%b exp 00", Done, RFwrEn); end
        vectors++; if ({FlagC, FlagZ} !== 2'b00) begin miscompares++; $display("FAIL rst_flags got %b exp 00", {FlagC, FlagZ}); end
        vectors++; if ({InsSel, ALUinA, ALUinB, RFwrAddr, RFwrData} !== 28'h0) begin miscompares++; $display("FAIL rst_regs got %h exp 0", {InsSel, ALUinA, ALUinB, RFwrAddr, RFwrData}); end
    endtask

    task automatic test_add;
        set_reg(2'd1, 8'h0F);
        set_reg(2'd2, 8'h01);
        set_reg(2'd3, 8'hEE);
        issue(2'b00, 2'd3, 2'd1, 2'd2);
        @(negedge clk);
        vectors++; if (Busy !== 1'b1 || InsReady !== 1'b0) begin miscompares++; $display("FAIL add_c1_busy got %b%b exp 10", Busy, InsReady); end
        vectors++; if ({RFrdAddrA, RFrdAddrB} !== 4'b0110) begin miscompares++; $display("FAIL add_c1_rdaddr got %b exp 0110", {RFrdAddrA, RFrdAddrB}); end
        vectors++; if (Done !== 1'b0) begin miscompares++; $display("FAIL add_c1_done got %b exp 0", Done); end
        @(negedge clk);
        vectors++; if ({InsSel, ALUinA, ALUinB} !== {2'b00, 8'h0F, 8'h01}) begin miscompares++; $display("FAIL add_c2_alu got %h exp 00f01", {InsSel, ALUinA, ALUinB}); end
        vectors++; if (Done !== 1'b0 || RFwrEn !== 1'b0) begin miscompares++; $display("FAIL add_c2_done_wr got %b%b exp 00", Done, RFwrEn); end
        @(negedge clk);
        vectors++; if (Done !== 1'b1 || RFwrEn !== 1'b1) begin miscompares++; $display("FAIL add_c3_done_wr got %b%b exp 11", Done, RFwrEn); end
        vectors++; if (RFwrAddr !== 2'd3 || RFwrData !== 8'h10) begin miscompares++; $display("FAIL add_c3_wdata got %0d/%h exp 3/10", RFwrAddr, RFwrData); end
        @(negedge clk);
        vectors++; if (Done !== 1'b0 || RFwrEn !== 1'b0 || InsReady !== 1'b1) begin miscompares++; $display("FAIL add_c4_ctl got %b%b%b exp 001", Done, RFwrEn, InsReady); end
        vectors++; if (rf[3] !== 8'h10) begin miscompares++; $display("FAIL add_r3 got %h exp 10", rf[3]); end
        vectors++; if ({FlagC, FlagZ} !== 2'b00) begin miscompares++; $display("FAIL add_flags got %b exp 00", {FlagC, FlagZ}); end
    endtask

    task automatic test_carry;
        set_reg(2'd0, 8'hAA);
        set_reg(2'd1, 8'hFF);
        set_reg(2'd2, 8'h01);
        issue(2'b00, 2'd0, 2'd1, 2'd2);
        repeat (3) @(negedge clk);
        vectors++; if ({FlagC, FlagZ} !== 2'b00) begin miscompares++; $display("FAIL carry_c3_flags_early got %b exp 00", {FlagC, FlagZ}); end
        @(negedge clk);
        vectors++; if (rf[0] !== 8'h00) begin miscompares++; $display("FAIL carry_r0 got %h exp 00", rf[0]); end
        vectors++; if ({FlagC, FlagZ} !== 2'b11) begin miscompares++; $display("FAIL carry_flags got %b exp 11", {FlagC, FlagZ}); end
    endtask

    task automatic test_reset_mid;
        set_reg(2'd2, 8'h77);
        set_reg(2'd1, 8'h10);
        issue(2'b00, 2'd2, 2'd1, 2'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++; if (RFwrEn !== 1'b0 || Done !== 1'b0) begin miscompares++; $display("FAIL rmid_wr_done got %b%b exp 00", RFwrEn, Done); end
        vectors++; if ({FlagC, FlagZ} !== 2'b00) begin miscompares++; $display("FAIL rmid_flags got %b exp 00", {FlagC, FlagZ}); end
        vectors++; if (InsReady !== 1'b1) begin miscompares++; $display("FAIL rmid_ready got %b exp 1", InsReady); end
        @(negedge clk);
        vectors++; if (Done !== 1'b0 || rf[2] !== 8'h77) begin miscompares++; $display("FAIL rmid_nowrite got %b/%h exp 0/77", Done, rf[2]); end
    endtask

    task automatic test_nowb;
        set_reg(2'd0, 8'hAA);
        set_reg(2'd1, 8'h55);
        set_reg(2'd2, 8'h55);
        set_reg(2'd3, 8'hC3);
        issue(2'b01, 2'd0, 2'd1, 2'd2);
        repeat (3) @(negedge clk);
        vectors++; if (Done !== 1'b1 || RFwrEn !== 1'b0) begin miscompares++; $display("FAIL nowb_c3 got done %b wr %b exp 1 0", Done, RFwrEn); end
        @(negedge clk);
        vectors++; if ({FlagC, FlagZ} !== 2'b01) begin miscompares++; $display("FAIL nowb_flags got %b exp 01", {FlagC, FlagZ}); end
        vectors++; if ({rf[0], rf[1], rf[2], rf[3]} !== 32'hAA5555C3) begin miscompares++; $display("FAIL nowb_rf got %h exp aa5555c3", {rf[0], rf[1], rf[2], rf[3]}); end
    endtask

    task automatic test_and;
        set_reg(2'd1, 8'hF0);
        set_reg(2'd2, 8'h3C);
        issue(2'b10, 2'd3, 2'd1, 2'd2);
        repeat (3) @(negedge clk);
        vectors++; if (RFwrEn !== 1'b1 || RFwrData !== 8'h30) begin miscompares++; $display("FAIL and_c3 got wr %b data %h exp 1 30", RFwrEn, RFwrData); end
        @(negedge clk);
        vectors++; if (rf[3] !== 8'h30 || {FlagC, FlagZ} !== 2'b00) begin miscompares++; $display("FAIL and_result got %h/%b exp 30/00", rf[3], {FlagC, FlagZ}); end
    endtask

    task automatic test_back_to_back;
        set_reg(2'd1, 8'h01);
        set_reg(2'd2, 8'h01);
        InsOp   = 2'b00;
        InsDst  = 2'd1;
        InsSrcA = 2'd1;
        InsSrcB = 2'd2;
        for (int t = 0; t <= 12; t++) begin
            @(negedge clk);
            vectors++; if (InsReady !== (t % 4 == 0)) begin miscompares++; $display("FAIL b2b_ready cycle %0d got %b exp %b", t, InsReady, (t % 4 == 0)); end
            vectors++; if (Done !== (t % 4 == 3)) begin miscompares++; $display("FAIL b2b_done cycle %0d got %b exp %b", t, Done, (t % 4 == 3)); end
            if (t == 0) InsValid = 1'b1;
            if (t == 9) InsValid = 1'b0;
        end
        vectors++; if (rf[1] !== 8'h04) begin miscompares++; $display("FAIL b2b_r1 got %h exp 04", rf[1]); end
    endtask

`ifdef ALU_SEQ_PERF_EN
    task automatic test_perf;
        for (int i = 0; i < 5; i++) begin
            issue(2'b11, 2'd3, 2'd1, 2'd2);
            repeat (4) @(negedge clk);
        end
        vectors++; if (OpCount !== 16'd5) begin miscompares++; $display("FAIL perf_count got %0d exp 5", OpCount); end
        @(negedge clk);
        force dut.op_count = 16'hFFFF;
        @(negedge clk);
        release dut.op_count;
        issue(2'b11, 2'd3, 2'd1, 2'd2);
        repeat (4) @(negedge clk);
        vectors++; if (OpCount !== 16'h0000) begin miscompares++; $display("FAIL perf_wrap got %h exp 0000", OpCount); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef ALU_SEQ_PERF_EN
        test_perf();
`endif
        test_add();
        test_carry();
        test_reset_mid();
        test_nowb();
        test_and();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle sequencer that executes one register-to-register ALU instruction at a time.
- Accepts an instruction over a valid/ready handshake, reads two operands from the register file and drives the ALU (InsSel/ALUinA/ALUinB).
- Captures ALUout, CO and Z, writes the result back to the register file and holds the carry and zero flags.
- Sits between the control unit and the existing ALU and RF blocks.

Parameters:
- DATA_W, 8, ALU/RF data width.
- ADDR_W, 2, RF address width (4 registers).
- NOWB_MASK, 4'b0000, bit n = 1 means InsOp n is compare-only: flags update, no RF write.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- InsValid  in  1  instruction present.
- InsReady  out  1  sequencer can accept an instruction.
- InsOp  in  2  ALU operation, forwarded to InsSel.
- InsDst  in  ADDR_W  destination register.
- InsSrcA  in  ADDR_W  operand A register.
- InsSrcB  in  ADDR_W  operand B register.
- RFrdAddrA  out  ADDR_W  RF read address A.
- RFrdAddrB  out  ADDR_W  RF read address B.
- RFrdDataA  in  DATA_W  RF read data A, combinational from address.
- RFrdDataB  in  DATA_W  RF read data B, combinational from address.
- RFwrEn  out  1  RF write strobe.
- RFwrAddr  out  ADDR_W  RF write address.
- RFwrData  out  DATA_W  RF write data.
- InsSel  out  2  ALU operation select.
- ALUinA  out  DATA_W  ALU operand A.
- ALUinB  out  DATA_W  ALU operand B.
- ALUout  in  DATA_W  ALU result.
- CO  in  1  ALU carry out.
- Z  in  1  ALU zero.
- FlagC  out  1  registered carry flag.
- FlagZ  out  1  registered zero flag.
- Busy  out  1  instruction in flight.
- Done  out  1  one-cycle completion pulse.

Behaviour:
- One clock (clk); reset rst is synchronous, active-high.
- Reset:
  - State = IDLE.
  - All registered outputs = 0: InsSel, ALUinA, ALUinB, RFwrEn, RFwrAddr, RFwrData, FlagC, FlagZ, Busy, Done.
  - Latched instruction fields = 0.
- FSM, binary-encoded: IDLE -> READ -> EXEC -> WRITE -> IDLE.
- IDLE:
  - InsReady = 1; Busy = 0.
  - On InsValid & InsReady at a clock edge: latch InsOp/InsDst/InsSrcA/InsSrcB and go to READ.
  - InsValid without handshake has no effect.
- READ:
  - RFrdAddrA/B = latched SrcA/SrcB.
  - At the edge, RFrdDataA/B are registered into ALUinA/ALUinB and the latched op into InsSel; go to EXEC.
- EXEC:
  - ALU inputs are stable from registers.
  - At the edge, capture ALUout into a result register and CO/Z into temporaries; go to WRITE.
- WRITE:
  - RFwrEn = ~NOWB_MASK[op].
  - RFwrAddr = latched Dst; RFwrData = captured result.
  - Done = 1 for exactly this cycle.
  - At the edge, FlagC/FlagZ take the captured CO/Z; go to IDLE.
- InsReady and Busy:
  - InsReady = 1 only in IDLE, decoded combinationally from state.
  - Busy = ~InsReady.
- Latency and throughput:
  - Handshake edge = cycle 0; Done and RFwrEn are high in cycle 3.
  - Flags are visible from cycle 4.
  - Throughput is 1 instruction per 4 cycles; the next handshake is possible in cycle 4.
- RFrdAddrA/B hold their last value outside READ.
- ALUinA/ALUinB/InsSel hold their last value until the next READ.
- Dst equal to SrcA/SrcB is legal; operands are read in READ before the write in WRITE.
- Instruction fields changing while Busy are ignored.
- Reset mid-operation (any state): return to IDLE next edge. No RF write occurs even if reset lands in WRITE, because RFwrEn is forced 0 in the reset cycle. Flags clear to 0.
- Flags change only in the WRITE->IDLE transition or on reset.

Optional Feature:
- Macro ALU_SEQ_PERF_EN.
- Defined:
  - Adds output port OpCount [15:0].
  - Reset to 0; +1 on each cycle where Done = 1.
  - Wraps 16'hFFFF -> 16'h0000.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Bench ALU model: 00 ADD, 01 SUB, 10 AND, 11 OR. Bench RF model: 4x8, combinational read.
- Reset, then R1=8'h0F, R2=8'h01; issue op 00, Dst 3, SrcA 1, SrcB 2 -> Done in cycle 3; R3=8'h10; FlagC=0, FlagZ=0 at cycle 4.
- R1=8'hFF, R2=8'h01, op 00, Dst 0 -> R0=8'h00; FlagC=1, FlagZ=1.
- NOWB_MASK=4'b0010, op 01 with R1=R2=8'h55 -> RFwrEn stays 0 in WRITE; FlagZ=1; no RF register changes.
- Hold InsValid high continuously with 3 instructions -> InsReady high only in IDLE; handshakes at cycles 0, 4, 8; Done at 3, 7, 11; Dst=SrcA chain (R1 <- R1 + R2 three times, R1=1, R2=1) gives R1=4.
- Assert rst for 1 cycle while in EXEC -> no RFwrEn pulse, no Done; FlagC=FlagZ=0; InsReady=1 next cycle.
- With ALU_SEQ_PERF_EN, 5 completed instructions -> OpCount=5; preload the counter to 16'hFFFF via forced sequence, run one more instruction -> OpCount=0.
